// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW = 5;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand source compare against the Memory and Writeback destinations.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              we_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              we_w,
  output logic [1:0]        sel
);

  // The younger result (Memory) wins; x0 never forwards.
  always_comb begin
    sel = FWD_RF;
    if (rs != '0 && we_m && rs == rd_m) begin
      sel = FWD_MEM;
    end else if (rs != '0 && we_w && rs == rd_w) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch handling, multicycle wait FSM.
// Forwarding is built only when HAZARD_FORWARD_EN is defined; otherwise hazards stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              McReqE,
  input  logic              McDone,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              McStart,
  output logic              McErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic              fsm_state
);

  localparam int WCW = $clog2(MC_TIMEOUT + 1);

  state_t           state, state_n;
  logic [WCW-1:0]   wait_cnt, wait_cnt_n;
  logic             set_err;
  logic [1:0]       sel_a, sel_b;
  logic             lw_stall;
  logic             load_use;

  assign load_use = ResultSrcE0 && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);

`ifdef HAZARD_FORWARD_EN
  fwd_sel u_fwd_a (.rs(Rs1E), .rd_m(RdM), .we_m(RegWriteM), .rd_w(RdW), .we_w(RegWriteW), .sel(sel_a));
  fwd_sel u_fwd_b (.rs(Rs2E), .rd_m(RdM), .we_m(RegWriteM), .rd_w(RdW), .we_w(RegWriteW), .sel(sel_b));
  assign lw_stall = load_use;
  logic unused_nofwd;
  assign unused_nofwd = RegWriteE;
`else
  // Without a bypass network the same compare finds Decode sources still in flight in E or M.
  fwd_sel u_fwd_a (.rs(Rs1D), .rd_m(RdM), .we_m(RegWriteM), .rd_w(RdE), .we_w(RegWriteE), .sel(sel_a));
  fwd_sel u_fwd_b (.rs(Rs2D), .rd_m(RdM), .we_m(RegWriteM), .rd_w(RdE), .we_w(RegWriteE), .sel(sel_b));
  assign lw_stall = load_use || (sel_a != FWD_RF) || (sel_b != FWD_RF);
  logic unused_fwd;
  assign unused_fwd = ^{Rs1E, Rs2E, RdW, RegWriteW};
`endif

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    set_err    = 1'b0;
    ForwardAE  = FWD_RF;
    ForwardBE  = FWD_RF;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    McStart    = 1'b0;
    if (reset) begin
      FlushD     = 1'b1;
      FlushE     = 1'b1;
      FlushM     = 1'b1;
      state_n    = RUN;
      wait_cnt_n = '0;
    end else begin
`ifdef HAZARD_FORWARD_EN
      ForwardAE = sel_a;
      ForwardBE = sel_b;
`endif
      case (state)
        RUN: begin
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else begin
            if (lw_stall) begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
            end
            if (McReqE) begin
              McStart    = 1'b1;
              StallF     = 1'b1;
              StallD     = 1'b1;
              StallE     = 1'b1;
              FlushM     = 1'b1;
              state_n    = MC_WAIT;
              wait_cnt_n = '0;
            end
          end
        end
        MC_WAIT: begin
          if (McDone) begin
            state_n    = RUN;
            wait_cnt_n = '0;
          end else begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            if (wait_cnt == WCW'(MC_TIMEOUT - 1)) begin
              set_err    = 1'b1;
              state_n    = RUN;
              wait_cnt_n = '0;
            end else begin
              wait_cnt_n = wait_cnt + WCW'(1);
            end
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      McErr    <= 1'b0;
      StallCnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (set_err) McErr <= 1'b1;
      if (StallD && StallCnt != '1) StallCnt <= StallCnt + CNT_W'(1);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McReqE, McDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, McStart, McErr, fsm_state;
  logic [CW-1:0] StallCnt;
  logic [6:0] ctl;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_cnt;

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, McStart}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b0001110;
  localparam logic [6:0] C_LW    = 7'b1100100;
  localparam logic [6:0] C_BR    = 7'b0001100;
  localparam logic [6:0] C_MCGO  = 7'b1110011;
  localparam logic [6:0] C_MCW   = 7'b1110010;

  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, McStart};

  hazard_ctrl #(.MC_TIMEOUT(64), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McReqE(McReqE), .McDone(McDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .McStart(McStart), .McErr(McErr), .StallCnt(StallCnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; checks follow 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; McReqE = 0; McDone = 0;
  endtask

  task automatic inc_exp();
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    // Hazardous inputs that must all be masked while reset is high
    McReqE = 1; Rs1E = 5; RdM = 5; RegWriteM = 1;
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; RegWriteE = 1;
    cyc(); cyc(); #1;
    total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
    total++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {ForwardAE, ForwardBE}); end
    total++; if ({fsm_state, McErr, StallCnt} !== {2'b00, {CW{1'b0}}}) begin bad++; $display("FAIL reset_state got=%b/%b/%0d exp=0/0/0", fsm_state, McErr, StallCnt); end
    idle();
    reset = 0;
    exp_cnt = 0;
  endtask

  task automatic test_forward();
    logic [1:0] ea, eb;
    cyc();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    #1;
`ifdef HAZARD_FORWARD_EN
    ea = 2'b10;
`else
    ea = 2'b00;
`endif
    total++; if (ForwardAE !== ea) begin bad++; $display("FAIL fwd_mem_prio got=%b exp=%b", ForwardAE, ea); end
    total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL fwd_no_stall got=%b exp=%b", ctl, C_IDLE); end
    cyc();
    RdM = 0; Rs2E = 5;
    #1;
`ifdef HAZARD_FORWARD_EN
    ea = 2'b01; eb = 2'b01;
`else
    ea = 2'b00; eb = 2'b00;
`endif
    total++; if ({ForwardAE, ForwardBE} !== {ea, eb}) begin bad++; $display("FAIL fwd_wb got=%b exp=%b", {ForwardAE, ForwardBE}, {ea, eb}); end
    cyc();
    RdW = 0; Rs1E = 0;
    #1;
    total++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin bad++; $display("FAIL fwd_x0 got=%b exp=0000", {ForwardAE, ForwardBE}); end
    idle();
  endtask

  task automatic test_load_use();
    cyc();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; RegWriteE = 1;
    #1;
    total++; if (ctl !== C_LW) begin bad++; $display("FAIL lw_stall got=%b exp=%b", ctl, C_LW); end
    inc_exp();
    cyc();
    idle();
    #1;
    total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL lw_release got=%b exp=%b", ctl, C_IDLE); end
    total++; if (StallCnt !== exp_cnt) begin bad++; $display("FAIL lw_cnt got=%0d exp=%0d", StallCnt, exp_cnt); end
    // RdE = x0 never creates a load-use hazard
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    #1;
    total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL lw_x0 got=%b exp=%b", ctl, C_IDLE); end
    cyc();
    idle();
    RegWriteM = 1; RdM = 9; Rs1D = 9;
    #1;
`ifdef HAZARD_FORWARD_EN
    total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL mem_dep got=%b exp=%b", ctl, C_IDLE); end
`else
    total++; if (ctl !== C_LW) begin bad++; $display("FAIL mem_dep got=%b exp=%b", ctl, C_LW); end
    inc_exp();
`endif
    cyc();
    idle();
    #1;
    total++; if (StallCnt !== exp_cnt) begin bad++; $display("FAIL dep_cnt got=%0d exp=%0d", StallCnt, exp_cnt); end
  endtask

  task automatic test_branch();
    cyc();
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7; RegWriteE = 1; PCSrcE = 1;
    #1;
    total++; if (ctl !== C_BR) begin bad++; $display("FAIL br_over_lw got=%b exp=%b", ctl, C_BR); end
    cyc();
    idle();
    PCSrcE = 1; McReqE = 1;
    #1;
    total++; if (ctl !== C_BR) begin bad++; $display("FAIL br_over_mc got=%b exp=%b", ctl, C_BR); end
    cyc();
    idle();
    #1;
    total++; if (fsm_state !== 1'b0) begin bad++; $display("FAIL br_state got=%b exp=0", fsm_state); end
    total++; if (StallCnt !== exp_cnt) begin bad++; $display("FAIL br_cnt got=%0d exp=%0d", StallCnt, exp_cnt); end
  endtask

  task automatic test_mc_done();
    int starts = 0;
    int errs = 0;
    cyc();
    McReqE = 1;
    #1;
    total++; if (ctl !== C_MCGO) begin bad++; $display("FAIL mc_start got=%b exp=%b", ctl, C_MCGO); end
    starts += int'(McStart);
    inc_exp();
    for (int i = 0; i < 10; i++) begin
      cyc();
      McReqE = i[0]; PCSrcE = ~i[0];
      #1;
      if (ctl !== C_MCW) errs++;
      starts += int'(McStart);
      inc_exp();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL mc_wait_hold got=%0d exp=0 bad cycles", errs); end
    cyc();
    McReqE = 0; PCSrcE = 0; McDone = 1;
    #1;
    total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL mc_done_release got=%b exp=%b", ctl, C_IDLE); end
    cyc();
    idle();
    #1;
    starts += int'(McStart);
    total++; if (starts != 1) begin bad++; $display("FAIL mc_pulses got=%0d exp=1", starts); end
    total++; if ({fsm_state, McErr} !== 2'b00) begin bad++; $display("FAIL mc_end_state got=%b exp=00", {fsm_state, McErr}); end
    total++; if (StallCnt !== exp_cnt) begin bad++; $display("FAIL mc_cnt got=%0d exp=%0d", StallCnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    int errs = 0;
    cyc();
    McReqE = 1;
    #1;
    inc_exp();
    cyc();
    McReqE = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (ctl !== C_MCW || McErr !== 1'b0 || fsm_state !== 1'b1) errs++;
      inc_exp();
      cyc();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL to_wait got=%0d exp=0 bad cycles", errs); end
    #1;
    total++; if ({McErr, fsm_state} !== 2'b10) begin bad++; $display("FAIL to_err got=%b exp=10", {McErr, fsm_state}); end
    total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL to_release got=%b exp=%b", ctl, C_IDLE); end
    // Sticky across idle time and a later successful operation
    cyc(); cyc();
    McReqE = 1;
    #1;
    inc_exp();
    cyc();
    McReqE = 0; McDone = 1;
    cyc();
    idle();
    #1;
    total++; if (McErr !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", McErr); end
    total++; if (StallCnt !== exp_cnt) begin bad++; $display("FAIL to_cnt got=%0d exp=%0d", StallCnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    int starts = 0;
    cyc();
    McReqE = 1;
    cyc(); cyc(); cyc();
    McReqE = 1; reset = 1;
    #1;
    total++; if (ctl !== C_RST) begin bad++; $display("FAIL rstmid_ctl got=%b exp=%b", ctl, C_RST); end
    cyc();
    reset = 0; McReqE = 0;
    exp_cnt = 0;
    #1;
    total++; if ({fsm_state, McErr, StallCnt} !== {2'b00, {CW{1'b0}}}) begin bad++; $display("FAIL rstmid_state got=%b/%b/%0d exp=0/0/0", fsm_state, McErr, StallCnt); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      starts += int'(McStart) + int'(StallD);
    end
    total++; if (starts != 0 || fsm_state !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%0d/%b exp=0/0", starts, fsm_state); end
  endtask

  task automatic test_saturate();
    cyc();
    ResultSrcE0 = 1; RdE = 3; Rs1D = 3; RegWriteE = 1;
    for (int i = 0; i < 260; i++) begin
      inc_exp();
      cyc();
    end
    idle();
    #1;
    total++; if (StallCnt !== exp_cnt || exp_cnt !== 8'hFF) begin bad++; $display("FAIL sat_cnt got=%0d exp=%0d", StallCnt, 255); end
  endtask

  initial begin
    idle();
    reset = 1;
    exp_cnt = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mc_done();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
